pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter and fetch sequencer sitting directly downstream of the branch-select stage. Consumes the 2-bit `PCSel` decision, computes and registers the next PC, issues instruction-fetch requests to instruction memory with a req/ack handshake, and holds the fetched instruction for the datapath until it signals completion. Also provides the link address for calls, a retired-instruction counter and a sticky fault/halt status.

## Interface
Parameters:
- `PC_WIDTH`, 32, PC and address width (bytes).
- `OFF_WIDTH`, 26, width of the signed word offset from the instruction.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  the only clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `PCSel`  in  2  next-PC select from the branch-select stage.
- `Offset`  in  OFF_WIDTH  signed branch offset in words.
- `RegTarget`  in  PC_WIDTH  register jump target (byte address).
- `ExecDone`  in  1  datapath has finished the current instruction.
- `Halt`  in  1  current instruction is a halt; sampled with `ExecDone`.
- `IMemAck`  in  1  instruction memory returns data this cycle.
- `IMemData`  in  32  instruction word.
- `IMemReq`  out  1  fetch request.
- `IMemAddr`  out  PC_WIDTH  fetch address; always equals `PC`.
- `PC`  out  PC_WIDTH  current PC.
- `Instr`  out  32  latched instruction.
- `InstrValid`  out  1  one-cycle pulse when `Instr` is newly loaded.
- `LinkPC`  out  PC_WIDTH  `PC + 4`; combinational.
- `RetireCount`  out  32  instructions retired.
- `Halted`  out  1  sequencer is stopped.
- `Fault`  out  1  sticky misaligned-jump fault.

## Operation
- `PCSel` encoding:
  - 00: sequential, next PC = PC+4.
  - 01: unconditional branch, next PC = PC+4+(sext(Offset)<<2).
  - 11: conditional branch taken; same target as 01.
  - 10: register jump, next PC = RegTarget.
- All PC arithmetic wraps modulo 2^PC_WIDTH.
- States: FETCH, EXEC, HALTED.
- FETCH:
  - `IMemReq`=1 and `IMemAddr`=PC.
  - On `IMemAck`: latch `IMemData` into `Instr`, pulse `InstrValid` the next cycle, go to EXEC.
- EXEC:
  - `IMemReq`=0.
  - Wait for `ExecDone`. When `ExecDone` is seen:
    - Increment `RetireCount` (wraps).
    - If `Halt`=1: PC holds and go to HALTED.
    - Else if `PCSel`=10 and `RegTarget[1:0]`≠0: set `Fault`, PC holds, go to HALTED.
    - Else: load next PC and go to FETCH.
- HALTED: `Halted`=1 and `IMemReq`=0. Only `rst` leaves this state.
- Ignored inputs:
  - `IMemAck` outside FETCH.
  - `ExecDone` outside EXEC.
  - `PCSel`/`Offset`/`RegTarget` except in the `ExecDone` cycle.
- `Halt` and misalignment in the same cycle: the instruction retires, `Fault` stays 0 (halt wins).

## Timing
- Reset values:
  - `PC`=`RESET_PC`, `Instr`=0, `InstrValid`=0, `RetireCount`=0, `Halted`=0, `Fault`=0.
  - State is FETCH.
  - `IMemReq`=0 during the reset cycle and is asserted the first cycle after `rst` deasserts.
- `rst` asserted in any state, including mid-fetch with a pending ack, returns all of the above on the next edge. Any ack in that cycle is discarded.
- Ack in the first request cycle (zero-wait memory):
  - Edge N samples the ack.
  - `InstrValid`=1 and state is EXEC in cycle N+1.
- `ExecDone` sampled at edge M:
  - New `PC`/`IMemAddr` is visible in cycle M+1 with `IMemReq`=1.
  - Minimum loop is 2 cycles per instruction.
- `IMemReq` stays high until ack; `IMemAddr` is stable while the request is held.
- `LinkPC` follows `PC` combinationally.

## Structure
- Shared package `kgp_pc_pkg`:
  - `PCSel` encodings (`PCSEL_SEQ`, `PCSEL_BR`, `PCSEL_BRC`, `PCSEL_JR`).
  - Sequencer state enum.
  - `INSTR_BYTES`=4.
- Sub-module `next_pc_calc`: purely combinational. Inputs PC, PCSel, Offset, RegTarget; outputs next PC and a misalign flag.
- FSM, PC register, instruction latch and counter live in `pc_sequencer`.

## Test plan
- Reset, then sequential run with zero-wait memory and `PCSel`=00 → `IMemAddr` 0x0, 0x4, 0x8; `RetireCount`=3 after three `ExecDone`s.
- At PC=0x100: `PCSel`=01 with Offset=-2 → next `IMemAddr`=0xFC. `PCSel`=11 with Offset=3 → next `IMemAddr`=0x110.
- `PCSel`=10 with RegTarget=0x2000 → fetch at 0x2000. RegTarget=0x2002 → `Fault`=1, `Halted`=1, PC holds, `IMemReq`=0.
- Memory acks after 3 wait cycles → `IMemReq` held for 4 cycles with a stable address. Stray `IMemAck`/`ExecDone` in the wrong state → no state change.
- Wrap and halt:
  - PC=0xFFFFFFFC with `PCSel`=00 → next PC=0x0.
  - `Halt` with `ExecDone` → `Halted`=1, count increments, PC unchanged.
  - Then `rst` → PC=`RESET_PC`, flags clear.
- `rst` asserted while `IMemReq`=1 with a simultaneous `IMemAck` → `InstrValid` stays 0 and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/kgp_pc_pkg.sv
// Shared definitions for the program-counter / fetch sequencer.
//   - PCSel encodings driven by the branch-select stage
//   - sequencer state enumeration
//   - instruction size in bytes
package kgp_pc_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;  // PC + 4
  localparam logic [1:0] PCSEL_BR  = 2'b01;  // unconditional branch
  localparam logic [1:0] PCSEL_BRC = 2'b11;  // conditional branch, taken
  localparam logic [1:0] PCSEL_JR  = 2'b10;  // register jump

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } seq_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC computation.
// Ports:
//   i_pc         current PC (byte address)
//   i_pcsel      next-PC select (kgp_pc_pkg PCSEL_* encodings)
//   i_offset     signed branch offset in instruction words
//   i_regtarget  register jump target (byte address)
//   o_next_pc    selected next PC, wraps modulo 2^PC_WIDTH
//   o_misalign   register jump target is not word aligned
module next_pc_calc
  import kgp_pc_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int OFF_WIDTH = 26
) (
  input  logic                        i_pc_dummy_unused_guard,
  input  logic        [PC_WIDTH-1:0]  i_pc,
  input  logic        [1:0]           i_pcsel,
  input  logic signed [OFF_WIDTH-1:0] i_offset,
  input  logic        [PC_WIDTH-1:0]  i_regtarget,
  output logic        [PC_WIDTH-1:0]  o_next_pc,
  output logic                        o_misalign
);

  logic        [PC_WIDTH-1:0] w_seq;
  logic signed [PC_WIDTH-1:0] w_off_sx;
  logic        [PC_WIDTH-1:0] w_branch;

  assign w_seq    = i_pc + PC_WIDTH'(INSTR_BYTES);
  // Sized cast of a signed operand sign-extends the word offset.
  assign w_off_sx = PC_WIDTH'(i_offset);
  // Branch targets are relative to the following instruction.
  assign w_branch = w_seq + PC_WIDTH'(w_off_sx <<< 2);

  always_comb begin
    o_next_pc  = w_seq;
    o_misalign = 1'b0;
    case (i_pcsel)
      PCSEL_BR, PCSEL_BRC: o_next_pc = w_branch;
      PCSEL_JR: begin
        o_next_pc  = i_regtarget;
        o_misalign = (i_regtarget[1:0] != 2'b00) | (i_pc_dummy_unused_guard & 1'b0);
      end
      default: o_next_pc = w_seq;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer.
// Takes the PCSel decision for the instruction in flight, fetches the next
// instruction over a req/ack handshake and holds it for the datapath until
// ExecDone. Counts retired instructions and parks in HALTED on a halt
// instruction or a misaligned register jump (sticky Fault).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PCSel/Offset/RegTarget   next-PC controls, sampled only with ExecDone
//   ExecDone, Halt           instruction completion / halt indication
//   IMemReq/IMemAddr         fetch request and address (address == PC)
//   IMemAck/IMemData         fetch response
//   PC, LinkPC               current PC and PC + 4
//   Instr, InstrValid        latched instruction, one-cycle load pulse
//   RetireCount              retired instruction count (wraps)
//   Halted, Fault            stopped status, sticky misalignment fault
module pc_sequencer
  import kgp_pc_pkg::*;
#(
  parameter int                 PC_WIDTH  = 32,
  parameter int                 OFF_WIDTH = 26,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic        [1:0]           PCSel,
  input  logic signed [OFF_WIDTH-1:0] Offset,
  input  logic        [PC_WIDTH-1:0]  RegTarget,
  input  logic                        ExecDone,
  input  logic                        Halt,
  input  logic                        IMemAck,
  input  logic        [31:0]          IMemData,
  output logic                        IMemReq,
  output logic        [PC_WIDTH-1:0]  IMemAddr,
  output logic        [PC_WIDTH-1:0]  PC,
  output logic        [31:0]          Instr,
  output logic                        InstrValid,
  output logic        [PC_WIDTH-1:0]  LinkPC,
  output logic        [31:0]          RetireCount,
  output logic                        Halted,
  output logic                        Fault
);

  seq_state_e          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_instr;
  logic                r_instr_vld;
  logic [31:0]         r_retire;
  logic                r_halted;
  logic                r_fault;

  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_misalign;

  next_pc_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_next_pc (
    .i_pc_dummy_unused_guard (1'b0),
    .i_pc                    (r_pc),
    .i_pcsel                 (PCSel),
    .i_offset                (Offset),
    .i_regtarget             (RegTarget),
    .o_next_pc               (w_next_pc),
    .o_misalign              (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_instr_vld <= 1'b0;
      r_retire    <= '0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_instr_vld <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (IMemAck) begin
            r_instr     <= IMemData;
            r_instr_vld <= 1'b1;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ExecDone) begin
            r_retire <= r_retire + 32'd1;
            // Halt takes priority over a misaligned jump in the same cycle.
            if (Halt) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else if (w_misalign) begin
              r_fault  <= 1'b1;
              r_halted <= 1'b1;
              r_state  <= ST_HALTED;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALTED: r_halted <= 1'b1;
        default:   r_state  <= ST_FETCH;
      endcase
    end
  end

  // Request is masked while rst is high so no fetch is issued in the reset cycle.
  assign IMemReq     = (r_state == ST_FETCH) && !rst;
  assign IMemAddr    = r_pc;
  assign PC          = r_pc;
  assign LinkPC      = r_pc + PC_WIDTH'(INSTR_BYTES);
  assign Instr       = r_instr;
  assign InstrValid  = r_instr_vld;
  assign RetireCount = r_retire;
  assign Halted      = r_halted;
  assign Fault       = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSel;
  logic [25:0] Offset;
  logic [31:0] RegTarget;
  logic        ExecDone, Halt, IMemAck;
  logic [31:0] IMemData;
  logic        IMemReq, InstrValid, Halted, Fault;
  logic [31:0] IMemAddr, PC, Instr, LinkPC, RetireCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_WIDTH(32), .OFF_WIDTH(26), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .Offset(Offset), .RegTarget(RegTarget),
    .ExecDone(ExecDone), .Halt(Halt), .IMemAck(IMemAck), .IMemData(IMemData),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .PC(PC), .Instr(Instr),
    .InstrValid(InstrValid), .LinkPC(LinkPC), .RetireCount(RetireCount),
    .Halted(Halted), .Fault(Fault)
  );

  typedef struct {
    logic [31:0] addr;   // address this step must fetch from
    int          wait_n; // wait cycles before ack
    logic [1:0]  sel;
    logic [25:0] off;
    logic [31:0] rt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction: check the held request, inject stray ExecDone
  // while waiting, ack after wait_n cycles.
  task automatic do_fetch(input logic [31:0] addr, input int wait_n,
                          input logic [31:0] data, input logic [31:0] cnt);
    for (int w = 0; w <= wait_n; w++) begin
      chk("req_held", {31'b0, IMemReq}, 32'd1);
      chk("fetch_addr", IMemAddr, addr);
      chk("linkpc", LinkPC, addr + 32'd4);
      chk("valid_idle", {31'b0, InstrValid}, 32'd0);
      IMemData = data;
      IMemAck  = (w == wait_n);
      ExecDone = (w != wait_n);
      tick();
    end
    IMemAck  = 1'b0;
    ExecDone = 1'b0;
    chk("instr", Instr, data);
    chk("valid_pulse", {31'b0, InstrValid}, 32'd1);
    chk("req_exec", {31'b0, IMemReq}, 32'd0);
    chk("cnt_stray", RetireCount, cnt);
  endtask

  // Execute: one cycle with stray ack and a bogus misaligned jump, then ExecDone.
  task automatic do_exec(input logic [31:0] data, input logic [1:0] sel,
                         input logic [25:0] off, input logic [31:0] rt,
                         input logic hlt, input logic [31:0] cnt);
    IMemAck   = 1'b1;
    IMemData  = ~data;
    PCSel     = 2'b10;
    RegTarget = 32'h3;
    tick();
    IMemAck = 1'b0;
    chk("instr_hold", Instr, data);
    chk("valid_drop", {31'b0, InstrValid}, 32'd0);
    chk("fault_idle", {31'b0, Fault}, 32'd0);
    ExecDone  = 1'b1;
    Halt      = hlt;
    PCSel     = sel;
    Offset    = off;
    RegTarget = rt;
    tick();
    ExecDone = 1'b0;
    Halt     = 1'b0;
    chk("retire", RetireCount, cnt);
  endtask

  initial begin
    rst = 1'b1; PCSel = 2'b00; Offset = '0; RegTarget = '0;
    ExecDone = 1'b0; Halt = 1'b0; IMemAck = 1'b0; IMemData = '0;

    vecs[0] = '{32'h0000_0000, 0, 2'b00, 26'd0,         32'h0};
    vecs[1] = '{32'h0000_0004, 0, 2'b00, 26'd0,         32'h0};
    vecs[2] = '{32'h0000_0008, 0, 2'b10, 26'd0,         32'h100};
    vecs[3] = '{32'h0000_0100, 0, 2'b01, 26'h3FF_FFFE,  32'h0};
    vecs[4] = '{32'h0000_00FC, 3, 2'b10, 26'd0,         32'h100};
    vecs[5] = '{32'h0000_0100, 0, 2'b11, 26'd3,         32'h0};
    vecs[6] = '{32'h0000_0110, 1, 2'b10, 26'd0,         32'h2000};
    vecs[7] = '{32'h0000_2000, 0, 2'b10, 26'd0,         32'hFFFF_FFFC};
    vecs[8] = '{32'hFFFF_FFFC, 0, 2'b00, 26'd0,         32'h0};
    vecs[9] = '{32'h0000_0000, 0, 2'b00, 26'd0,         32'h0};

    // Reset state (rst still high: no request)
    tick(); tick();
    chk("rst_req", {31'b0, IMemReq}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst_cnt", RetireCount, 32'd0);
    chk("rst_halted", {31'b0, Halted}, 32'd0);
    chk("rst_fault", {31'b0, Fault}, 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].addr, vecs[i].wait_n, 32'hA500_0000 | i, i);
      do_exec(32'hA500_0000 | i, vecs[i].sel, vecs[i].off, vecs[i].rt, 1'b0, i + 1);
    end

    // Misaligned register jump from PC 0x4 -> fault and halt, PC holds
    do_fetch(32'h4, 0, 32'h1234_5678, 32'd10);
    do_exec(32'h1234_5678, 2'b10, 26'd0, 32'h2002, 1'b0, 32'd11);
    chk("mis_fault", {31'b0, Fault}, 32'd1);
    chk("mis_halted", {31'b0, Halted}, 32'd1);
    chk("mis_pc", PC, 32'h4);
    chk("mis_req", {31'b0, IMemReq}, 32'd0);

    // Reset clears fault/halt
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_pc", PC, 32'h0);
    chk("rst2_fault", {31'b0, Fault}, 32'd0);
    chk("rst2_halted", {31'b0, Halted}, 32'd0);
    chk("rst2_cnt", RetireCount, 32'd0);

    // Halt together with a misaligned jump: halt wins, no fault
    do_fetch(32'h0, 0, 32'hCAFE_0001, 32'd0);
    do_exec(32'hCAFE_0001, 2'b10, 26'd0, 32'h2002, 1'b1, 32'd1);
    chk("halt_halted", {31'b0, Halted}, 32'd1);
    chk("halt_fault", {31'b0, Fault}, 32'd0);
    chk("halt_pc", PC, 32'h0);
    chk("halt_req", {31'b0, IMemReq}, 32'd0);
    // Stray ack/done while halted change nothing
    IMemAck = 1'b1; ExecDone = 1'b1; IMemData = 32'h5555_5555;
    tick(); tick();
    IMemAck = 1'b0; ExecDone = 1'b0;
    chk("hstay_halted", {31'b0, Halted}, 32'd1);
    chk("hstay_cnt", RetireCount, 32'd1);
    chk("hstay_instr", Instr, 32'hCAFE_0001);
    chk("hstay_valid", {31'b0, InstrValid}, 32'd0);
    chk("hstay_req", {31'b0, IMemReq}, 32'd0);

    // Reset again, run one instruction so PC != RESET_PC, then reset mid-fetch with ack
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    do_fetch(32'h0, 0, 32'h0BAD_0000, 32'd0);
    do_exec(32'h0BAD_0000, 2'b00, 26'd0, 32'h0, 1'b0, 32'd1);
    chk("pre_addr", IMemAddr, 32'h4);
    chk("pre_req", {31'b0, IMemReq}, 32'd1);
    rst = 1'b1; IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
    tick();
    IMemAck = 1'b0;
    chk("rack_valid", {31'b0, InstrValid}, 32'd0);
    chk("rack_instr", Instr, 32'h0);
    chk("rack_pc", PC, 32'h0);
    chk("rack_req_in_rst", {31'b0, IMemReq}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rack_req_after", {31'b0, IMemReq}, 32'd1);
    chk("rack_addr", IMemAddr, 32'h0);
    tick();
    chk("rack_valid2", {31'b0, InstrValid}, 32'd0);
    chk("rack_cnt", RetireCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
